// File: rtl/rr_arbiter_4_enc.sv
// Four-requester round-robin arbiter with registered grant index, hold timeout
// and a one-cycle pre-emption pulse after a timeout-only release.
module rr_arbiter_4_enc #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       preempt_q, preempt_d;

  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] pick_off;
  logic [1:0] pick_idx;
  logic       rel_done, rel_req, rel_to;

  // Rotate requests so that bit 0 corresponds to the requester at ptr.
  assign req_dbl = {req, req};
  assign req_rot = 4'(req_dbl >> ptr_q);

  always_comb begin
    pick_off = 2'd0;
    if (req_rot[0])      pick_off = 2'd0;
    else if (req_rot[1]) pick_off = 2'd1;
    else if (req_rot[2]) pick_off = 2'd2;
    else if (req_rot[3]) pick_off = 2'd3;
  end

  assign pick_idx = ptr_q + pick_off;

  assign rel_done = done;
  assign rel_req  = ~req[gnt_idx_q];
  assign rel_to   = (hold_cnt_q == HoldLast);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = 8'd0;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        if (rel_done || rel_req || rel_to) begin
          state_d     = StIdle;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 2'd1;
          preempt_d   = rel_to && !rel_done && !rel_req;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd0;
      gnt_idx_q   <= 2'd0;
      hold_cnt_q  <= 8'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule
